fpga_exit_status_uart: RTL
==========================

Name: fpga_exit_status_uart

Overview:
- Downstream of the FPGA top-level wrapper. Consumes the x_heep_system program-exit signals: exit_valid and the full 32-bit exit_value.
- Reports the exit code on a spare UART pin as the ASCII line "EXIT=XXXXXXXX\r\n", with 8 uppercase hex digits, MSB first.
- Drives pass/fail LEDs so board runs report status without a debugger attached.

Parameters:
- CLKS_PER_BIT, default 868: clk_i cycles per UART bit (100 MHz / 115200). Legal values are 2 or more.

Ports:
- clk_i  in  1  system clock (the wrapper's generated clock)
- rst_ni  in  1  asynchronous active-low reset
- exit_valid_i  in  1  program-exit flag, synchronous to clk_i
- exit_value_i  in  32  program exit code, stable while exit_valid_i is high
- tx_o  out  1  UART 8N1 serial output, idle high
- busy_o  out  1  message transmission in progress
- done_o  out  1  sticky: at least one full message has been sent since reset
- pass_led_o  out  1  done_o and captured value == 0
- fail_led_o  out  1  done_o and captured value != 0

Behaviour:
- Reset is asynchronous, active-low; one clock, clk_i.
- Values while rst_ni is low:
  - tx_o = 1; busy_o = 0; done_o = 0; pass_led_o = 0; fail_led_o = 0.
  - Captured value = 0; exit_valid_i history flop = 0; all counters = 0; FSM in IDLE.
- Trigger:
  - A trigger is a clock edge where exit_valid_i = 1 and the history flop = 0.
  - The history flop is updated on every clock.
  - If exit_valid_i is already high when reset deasserts, the first edge after reset triggers.
  - On a trigger in IDLE:
    - exit_value_i is captured and busy_o is set.
    - The FSM enters START with the character index = 0.
    - tx_o goes low on that same edge (registered output, zero extra latency).
  - Triggers while busy_o = 1 are ignored. Nothing is queued and the captured value does not change.
  - exit_valid_i held high produces exactly one message.
- Message, 15 characters, index 0..14:
  - 0..4 = 'E' 'X' 'I' 'T' '='.
  - 5..12 = hex nibbles of the captured value, bits [31:28] first down to [3:0]. Nibble 0-9 maps to 0x30+n; 10-15 maps to 0x41+(n-10).
  - 13 = 0x0D, 14 = 0x0A.
- FSM:
  - States: IDLE, START, DATA, STOP.
  - The bit-cycle counter runs 0..CLKS_PER_BIT-1. Each state holds its tx_o level for exactly CLKS_PER_BIT cycles.
  - START: tx_o = 0.
  - DATA: 8 bits, LSB first, tx_o = current bit. The bit index runs 0..7.
  - STOP: tx_o = 1.
  - At the end of STOP with index < 14: increment the index and go directly to START, with no idle gap between characters.
  - At the end of STOP with index = 14: go to IDLE, clear busy_o, set done_o.
- Timing:
  - One character is 10*CLKS_PER_BIT cycles.
  - The full message is 150*CLKS_PER_BIT cycles from the trigger edge to busy_o falling.
- Retrigger: after returning to IDLE, a new trigger starts a new message with a freshly captured value.
- LEDs:
  - pass_led_o and fail_led_o update from the currently captured value while done_o = 1.
  - A retrigger captures a new value, so the LEDs reflect the new value immediately.
- Counter widths:
  - Bit-cycle counter = $clog2(CLKS_PER_BIT), and no wrap occurs outside 0..CLKS_PER_BIT-1.
  - Character index = 4 bits; bit index = 3 bits.
- Reset mid-frame: all outputs return to reset values asynchronously. No partial character resumes after reset is released.

Test Plan:
- CLKS_PER_BIT=4, exit_value_i=0x00000000, pulse exit_valid_i:
  - Required: decoded bytes 45 58 49 54 3D 30×8 0D 0A.
  - busy_o high for exactly 600 cycles.
  - Afterwards done_o=1, pass_led_o=1, fail_led_o=0.
- CLKS_PER_BIT=4, exit_value_i=0xDEADBEEF:
  - Required: digits "DEADBEEF" (44 45 41 44 42 45 45 46).
  - fail_led_o=1, pass_led_o=0.
  - tx_o low on the trigger edge; the first data bit ('E'=0x45, LSB=1) appears 4 cycles later.
- During a message, drop exit_valid_i, then re-raise it with value 0x1:
  - Required: the message still completes with the originally captured value.
  - No second message; busy_o falls at 600 cycles.
- Hold exit_valid_i high for 2000 cycles:
  - Required: exactly one message; tx_o stays idle high after it.
- Assert rst_ni low at cycle 100 of a message:
  - Required: tx_o=1 and busy_o=0 immediately, without waiting for a clock edge.
  - After release with exit_valid_i=0, tx_o stays high.
  - A later pulse sends a complete message.
- Send 0x0, then retrigger with 0x00000007:
  - Required: second message ends in "00000007\r\n".
  - LEDs switch from pass to fail at the retrigger edge.

Source files
------------

// File: rtl/fpga_exit_status_uart_if.sv
// Exit-status reporter bundle: program-exit inputs and
// UART/LED status outputs.
interface fpga_exit_status_uart_if;
   logic        exit_valid_i;
   logic [31:0] exit_value_i;
   logic        tx_o;
   logic        busy_o;
   logic        done_o;
   logic        pass_led_o;
   logic        fail_led_o;

   modport master (
      output exit_valid_i, exit_value_i,
      input  tx_o, busy_o, done_o, pass_led_o, fail_led_o
   );

   modport slave (
      input  exit_valid_i, exit_value_i,
      output tx_o, busy_o, done_o, pass_led_o, fail_led_o
   );
endinterface

// File: rtl/fpga_exit_status_uart.sv
// Sends "EXIT=XXXXXXXX\r\n" over UART 8N1 on a program-exit
// edge and drives pass/fail LEDs from the captured exit code.
module fpga_exit_status_uart #(
   parameter int CLKS_PER_BIT = 868
) (
   input logic clk_i,
   input logic rst_ni,
   fpga_exit_status_uart_if.slave bus
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    chr, chr_n;
   logic [2:0]    bitn, bit_n, bit_nx;
   logic [31:0]   value, value_n;
   logic          hist, tx, tx_n;
   logic          busy, busy_n, done, done_n;
   logic          trig, last;
   logic [7:0]    cur;

   function automatic logic [7:0] char_at(
      input logic [3:0] i, input logic [31:0] v);
      logic [3:0] n;
      logic [7:0] c;
      n = 4'h0;
      c = 8'h00;
      unique case (i)
         4'd5:    n = v[31:28];
         4'd6:    n = v[27:24];
         4'd7:    n = v[23:20];
         4'd8:    n = v[19:16];
         4'd9:    n = v[15:12];
         4'd10:   n = v[11:8];
         4'd11:   n = v[7:4];
         4'd12:   n = v[3:0];
         default: n = 4'h0;
      endcase
      unique case (i)
         4'd0:    c = 8'h45;
         4'd1:    c = 8'h58;
         4'd2:    c = 8'h49;
         4'd3:    c = 8'h54;
         4'd4:    c = 8'h3D;
         4'd13:   c = 8'h0D;
         4'd14:   c = 8'h0A;
         default: c = (n < 4'd10) ? (8'h30 + {4'h0, n})
                                  : (8'h37 + {4'h0, n});
      endcase
      return c;
   endfunction

   assign trig   = bus.exit_valid_i & ~hist;
   assign last   = (cnt == LAST);
   assign cur    = char_at(chr, value);
   assign bit_nx = bitn + 3'd1;

   // State, counters, capture and registered serial output
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         cnt   <= '0;
         chr   <= '0;
         bitn  <= '0;
         value <= '0;
         hist  <= 1'b0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         chr   <= chr_n;
         bitn  <= bit_n;
         value <= value_n;
         hist  <= bus.exit_valid_i;
         tx    <= tx_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   // Next state; tx_n is the level of the slot being entered
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      chr_n   = chr;
      bit_n   = bitn;
      value_n = value;
      tx_n    = tx;
      busy_n  = busy;
      done_n  = done;
      unique case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (trig) begin
               state_n = START;
               cnt_n   = '0;
               chr_n   = '0;
               bit_n   = '0;
               value_n = bus.exit_value_i;
               busy_n  = 1'b1;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (last) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = DATA;
               tx_n    = cur[0];
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (last) begin
               cnt_n = '0;
               if (bitn == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_nx;
                  tx_n  = cur[bit_nx];
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (last) begin
               cnt_n = '0;
               if (chr == 4'd14) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  tx_n    = 1'b1;
               end else begin
                  chr_n   = chr + 4'd1;
                  state_n = START;
                  tx_n    = 1'b0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
   end

   assign bus.tx_o       = tx;
   assign bus.busy_o     = busy;
   assign bus.done_o     = done;
   assign bus.pass_led_o = done & (value == 32'h0);
   assign bus.fail_led_o = done & (value != 32'h0);

endmodule
